// File: rtl/alu_op_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_op_decoder : 16-bit instruction to ALU micro-op decode stage        |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module alu_op_decoder #(
  parameter logic [3:0] NOP_OP       = 4'hF,
  parameter bit         ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        data_hazard,
  input  logic        flush,
  output logic        uop_valid,
  output logic [3:0]  alu_op,
  output logic [7:0]  I_field,
  output logic        h_en,
  output logic        l_en,
  output logic        set_cc,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic        wb_en,
  output logic        illegal_op,
  output logic        busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ROT  = 1'b1;

  logic [0:0] state, state_d;
  logic [3:0] rot_cnt, rot_cnt_d;
  logic       accept;
  logic       is_rot;
  logic       uop_valid_d, h_en_d, l_en_d, set_cc_d, wb_en_d, illegal_op_d;
  logic [3:0] alu_op_d, ra_d, rb_d;
  logic [7:0] I_field_d;

  assign instr_ready = rst_n & (state == S_IDLE) & ~data_hazard & ~flush;
  assign accept      = instr_valid & instr_ready;
  assign busy        = (state == S_ROT);
  assign is_rot      = instr[15] & (instr[14:13] == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rot_cnt    <= 4'd0;
      uop_valid  <= 1'b0;
      alu_op     <= NOP_OP;
      I_field    <= 8'd0;
      h_en       <= 1'b1;
      l_en       <= 1'b1;
      set_cc     <= 1'b0;
      ra         <= 4'd0;
      rb         <= 4'd0;
      wb_en      <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_d;
      rot_cnt    <= rot_cnt_d;
      uop_valid  <= uop_valid_d;
      alu_op     <= alu_op_d;
      I_field    <= I_field_d;
      h_en       <= h_en_d;
      l_en       <= l_en_d;
      set_cc     <= set_cc_d;
      ra         <= ra_d;
      rb         <= rb_d;
      wb_en      <= wb_en_d;
      illegal_op <= illegal_op_d;
    end
  end

  always_comb begin
    state_d   = state;
    rot_cnt_d = rot_cnt;
    if (!data_hazard) begin
      if (flush) begin
        state_d   = S_IDLE;
        rot_cnt_d = 4'd0;
      end else if (state == S_ROT) begin
        if (rot_cnt == 4'd1) begin
          state_d   = S_IDLE;
          rot_cnt_d = 4'd0;
        end else begin
          rot_cnt_d = rot_cnt - 4'd1;
        end
      end else if (accept && is_rot && (instr[3:0] >= 4'd2)) begin
        state_d   = S_ROT;
        rot_cnt_d = instr[3:0] - 4'd1;
      end
    end
  end

  // Default is hold; the rotate uop is re-emitted in ROT simply by not touching the fields.
  always_comb begin
    uop_valid_d  = uop_valid;
    alu_op_d     = alu_op;
    I_field_d    = I_field;
    h_en_d       = h_en;
    l_en_d       = l_en;
    set_cc_d     = set_cc;
    ra_d         = ra;
    rb_d         = rb;
    wb_en_d      = wb_en;
    illegal_op_d = 1'b0;
    if (data_hazard) begin
      illegal_op_d = 1'b0;
    end else if (flush) begin
      uop_valid_d = 1'b0;
      alu_op_d    = NOP_OP;
      wb_en_d     = 1'b0;
    end else if (state == S_ROT) begin
      uop_valid_d = 1'b1;
    end else if (accept && !instr[15]) begin
      uop_valid_d = 1'b1;
      alu_op_d    = instr[14:11];
      h_en_d      = instr[10];
      l_en_d      = instr[9];
      set_cc_d    = instr[8];
      ra_d        = instr[7:4];
      rb_d        = instr[3:0];
      I_field_d   = 8'd0;
      wb_en_d     = ~instr[8] & (instr[13:11] != 3'b111);
    end else if (accept) begin
      uop_valid_d = 1'b1;
      ra_d        = instr[11:8];
      rb_d        = 4'd0;
      set_cc_d    = 1'b0;
      h_en_d      = 1'b1;
      l_en_d      = 1'b1;
      I_field_d   = 8'd0;
      case (instr[14:12])
        3'b000, 3'b001, 3'b010: begin
          alu_op_d  = 4'b0111;
          I_field_d = instr[7:0];
          h_en_d    = (instr[14:12] == 3'b001);
          l_en_d    = (instr[14:12] == 3'b000);
          wb_en_d   = 1'b1;
        end
        3'b011: begin
          alu_op_d  = 4'b1111;
          I_field_d = {4'b0000, instr[3:0]};
          wb_en_d   = 1'b0;
        end
        3'b100, 3'b101: begin
          if (instr[3:0] == 4'd0) begin
            uop_valid_d = 1'b0;
            alu_op_d    = NOP_OP;
            wb_en_d     = 1'b0;
            ra_d        = ra;
            rb_d        = rb;
            h_en_d      = h_en;
            l_en_d      = l_en;
            I_field_d   = I_field;
          end else begin
            alu_op_d = instr[12] ? 4'b0011 : 4'b1011;
            wb_en_d  = 1'b1;
          end
        end
        3'b110: begin
          alu_op_d = 4'b0111;
          set_cc_d = 1'b1;
          wb_en_d  = 1'b0;
        end
        default: begin
          uop_valid_d  = 1'b0;
          alu_op_d     = NOP_OP;
          wb_en_d      = 1'b0;
          ra_d         = ra;
          rb_d         = rb;
          h_en_d       = h_en;
          l_en_d       = l_en;
          I_field_d    = I_field;
          illegal_op_d = ILLEGAL_TRAP;
        end
      endcase
    end else begin
      uop_valid_d = 1'b0;
      alu_op_d    = NOP_OP;
      wb_en_d     = 1'b0;
      set_cc_d    = 1'b0;
    end
  end

endmodule
`default_nettype wire
